cnu_min_accumulator: RTL and testbench
======================================

// Module: cnu_min_accumulator
// PURPOSE
//  Serial check-node min tracker for the layered min-sum LDPC decoder. Consumes one
//  sign-magnitude V2C message per beat for one parity row and keeps min1, min2,
//  index of min1 and the XOR of all signs. Feeds the min/second-min compare stage
//  and the C2C update. Holds one finished row result until downstream accepts it.
// PARAMETERS
//  NOB      4   magnitude bits; message is NOB+1 bits: [NOB]=sign, [NOB-1:0]=magnitude
//  DEG_MAX  19  max row degree (5G BG1); longer rows flag an error
//  IDX_W    5   index width; must satisfy 2**IDX_W >= DEG_MAX
//  OFFSET   1   offset subtracted at output when OFFSET_MS_EN is defined
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        in_msg/in_last valid
//  in_ready   out  1        accumulator can take a beat
//  in_msg     in   NOB+1    V2C message, sign-magnitude
//  in_last    in   1        final message of the row
//  out_valid  out  1        row result valid
//  out_ready  in   1        downstream accepts result
//  out_min1   out  NOB      smallest magnitude in row
//  out_min2   out  NOB      second smallest magnitude
//  out_idx    out  IDX_W    beat position (0-based) of min1
//  out_sign   out  1        XOR of all sign bits of the row
//  out_deg    out  IDX_W    beats received for the row, minus 1
//  deg_err    out  1        sticky: row exceeded DEG_MAX beats; cleared by reset only
// BEHAVIOUR
//  - Reset (async, rst_n=0): state ACC, in_ready=1, out_valid=0, all out_* = 0, deg_err=0;
//    working min1/min2 = all ones, count=0, sign=0. Row in progress is discarded.
//  - States: ACC (accepting), HOLD (result presented).
//    ACC: in_ready=1. Beat accepted when in_valid&in_ready. Per beat with magnitude m:
//      m <  min1 : min2<=min1, min1<=m, idx<=count
//      min1<=m<min2 : min2<=m (tie with min1 goes to min2; min1/idx keep earlier beat)
//      m >= min2 : no change. sign<=sign^in_msg[NOB]; count<=count+1.
//    ACC -> HOLD on accepted beat with in_last=1: out_* registered from the updated
//      values including that beat; out_valid=1 next cycle (latency 1 clk after last beat).
//      Working regs re-initialised same edge.
//    HOLD: in_ready=0, out_* stable while out_valid&!out_ready.
//      out_valid&out_ready -> ACC next cycle; out_valid drops. No back-to-back bypass:
//      min row-to-row gap is 1 cycle (HOLD cycle).
//  - Degree-1 row (in_last on first beat): out_min2 = all ones (2**NOB-1), out_idx=0.
//  - All-equal magnitudes: out_min1=out_min2=m, out_idx=0.
//  - Count reaching DEG_MAX without in_last: deg_err<=1; further beats still
//    accumulate, count saturates at DEG_MAX-1 (idx/out_deg never wrap).
//  - in_valid while in HOLD: ignored (not accepted); upstream must hold data.
//  - Unsigned compares only on magnitude; sign never affects min selection.
// CONFIGURATION
//  OFFSET_MS_EN defined: out_min1/out_min2 = max(min - OFFSET, 0), saturating at 0,
//    applied in the registering edge (no extra latency). Working regs unaffected.
//  OFFSET_MS_EN undefined: plain min-sum, out_min1/out_min2 = raw minima.
// TESTING
//  1 reset mid-row: 2 beats then rst_n=0 -> all outputs 0; next row mag {7,3,5} last
//    -> min1=3,min2=5,idx=1.
//  2 row {+6,-2,-9,+4,-1} (NOB=4) -> min1=1,min2=2,idx=4,sign=1,deg=4, out_valid 1 clk after last.
//  3 backpressure: out_ready=0 for 5 clks -> in_ready=0, out_* stable; accept -> in_ready=1 next clk.
//  4 degree-1 row {-5} -> min1=5,min2=15,idx=0,sign=1; ties {4,4,4} -> min1=4,min2=4,idx=0.
//  5 20 beats without in_last (DEG_MAX=19) -> deg_err=1 sticky, out_deg on last=18.
//  6 OFFSET_MS_EN, OFFSET=1, row {1,3} -> min1=0,min2=2; undefined -> min1=1,min2=3.

Source files
------------

// File: rtl/cnu_min_accumulator.sv
// ----------------------------------------------------------------------------
// cnu_min_accumulator
//
// Serial check-node min tracker for a layered min-sum LDPC decoder. One
// sign-magnitude V2C message arrives per beat for a single parity row. The
// block tracks the smallest magnitude (min1), the second smallest (min2), the
// beat position of min1 and the XOR of all sign bits. When the row's last beat
// is accepted the result is registered and held until downstream accepts it.
//
// Optional feature macro: OFFSET_MS_EN
//   defined   -> offset min-sum: out_min1/out_min2 = max(min - OFFSET, 0)
//   undefined -> plain min-sum: raw minima are presented
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_msg/in_last valid
//   in_ready   out  1      accumulator can take a beat (high in ACC)
//   in_msg     in   NOB+1  V2C message: [NOB]=sign, [NOB-1:0]=magnitude
//   in_last    in   1      final message of the row
//   out_valid  out  1      row result valid (high in HOLD)
//   out_ready  in   1      downstream accepts result
//   out_min1   out  NOB    smallest magnitude in row
//   out_min2   out  NOB    second smallest magnitude
//   out_idx    out  IDX_W  0-based beat position of min1
//   out_sign   out  1      XOR of all sign bits of the row
//   out_deg    out  IDX_W  beats received for the row minus 1
//   deg_err    out  1      sticky: a row exceeded DEG_MAX beats
// ----------------------------------------------------------------------------
module cnu_min_accumulator #(
    parameter int NOB     = 4,
    parameter int DEG_MAX = 19,
    parameter int IDX_W   = 5,
    parameter int OFFSET  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NOB:0]     in_msg,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NOB-1:0]   out_min1,
    output logic [NOB-1:0]   out_min2,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_sign,
    output logic [IDX_W-1:0] out_deg,
    output logic             deg_err
);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [NOB-1:0]   MAG_ONES = {NOB{1'b1}};
    localparam logic [NOB-1:0]   OFF_MAG  = NOB'(OFFSET);
    localparam logic [IDX_W-1:0] CNT_SAT  = IDX_W'(DEG_MAX - 1);

    // Output-side magnitude shaping, applied while registering the result.
    function automatic logic [NOB-1:0] shape_mag(input logic [NOB-1:0] m);
`ifdef OFFSET_MS_EN
        if (m > OFF_MAG) begin
            shape_mag = m - OFF_MAG;
        end else begin
            shape_mag = {NOB{1'b0}};
        end
`else
        shape_mag = m;
`endif
    endfunction

`ifndef OFFSET_MS_EN
    // The offset value only matters for offset min-sum builds.
    logic [NOB-1:0] unused_offset_s;
    assign unused_offset_s = OFF_MAG;
`endif

    state_t             state_r;
    state_t             state_s;

    logic [NOB-1:0]     min1_r;
    logic [NOB-1:0]     min2_r;
    logic [IDX_W-1:0]   idx_r;
    logic               sign_r;
    logic [IDX_W-1:0]   cnt_r;

    logic [NOB-1:0]     min1_s;
    logic [NOB-1:0]     min2_s;
    logic [IDX_W-1:0]   idx_s;
    logic               sign_s;
    logic [IDX_W-1:0]   cnt_s;

    logic               beat_s;
    logic [NOB-1:0]     mag_s;

    assign in_ready  = (state_r == ACC);
    assign out_valid = (state_r == HOLD);
    assign beat_s    = in_valid & in_ready;
    assign mag_s     = in_msg[NOB-1:0];

    // Working values after folding in the current beat's message.
    always_comb begin
        min1_s = min1_r;
        min2_s = min2_r;
        idx_s  = idx_r;
        if (mag_s < min1_r) begin
            // New strict minimum; the old min1 becomes the runner-up.
            min2_s = min1_r;
            min1_s = mag_s;
            idx_s  = cnt_r;
        end else if (mag_s < min2_r) begin
            // Includes a tie with min1: the earlier beat keeps min1/idx.
            min2_s = mag_s;
        end else begin
            min2_s = min2_r;
        end
        sign_s = sign_r ^ in_msg[NOB];
        // Saturate so idx/out_deg never wrap on over-long rows.
        if (cnt_r == CNT_SAT) begin
            cnt_s = cnt_r;
        end else begin
            cnt_s = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic for the accumulate/hold handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACC: begin
                if (beat_s && in_last) begin
                    state_s = HOLD;
                end else begin
                    state_s = ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = ACC;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = ACC;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACC;
        end else begin
            state_r <= state_s;
        end
    end

    // Working accumulators: load per beat, re-initialise at the end of a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min1_r <= MAG_ONES;
            min2_r <= MAG_ONES;
            idx_r  <= {IDX_W{1'b0}};
            sign_r <= 1'b0;
            cnt_r  <= {IDX_W{1'b0}};
        end else if (beat_s) begin
            if (in_last) begin
                min1_r <= MAG_ONES;
                min2_r <= MAG_ONES;
                idx_r  <= {IDX_W{1'b0}};
                sign_r <= 1'b0;
                cnt_r  <= {IDX_W{1'b0}};
            end else begin
                min1_r <= min1_s;
                min2_r <= min2_s;
                idx_r  <= idx_s;
                sign_r <= sign_s;
                cnt_r  <= cnt_s;
            end
        end
    end

    // Result registers: captured from the updated values on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_min1 <= {NOB{1'b0}};
            out_min2 <= {NOB{1'b0}};
            out_idx  <= {IDX_W{1'b0}};
            out_sign <= 1'b0;
            out_deg  <= {IDX_W{1'b0}};
        end else if (beat_s && in_last) begin
            out_min1 <= shape_mag(min1_s);
            out_min2 <= shape_mag(min2_s);
            out_idx  <= idx_s;
            out_sign <= sign_s;
            out_deg  <= cnt_r;
        end
    end

    // Sticky over-length flag: a non-final beat at the saturated count means
    // the row is longer than DEG_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deg_err <= 1'b0;
        end else if (beat_s && !in_last && (cnt_r == CNT_SAT)) begin
            deg_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnu_min_accumulator.sv
module tb_cnu_min_accumulator;

    localparam int NOB     = 4;
    localparam int DEG_MAX = 19;
    localparam int IDX_W   = 5;
    localparam int OFFSET  = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NOB:0]     in_msg = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NOB-1:0]   out_min1;
    logic [NOB-1:0]   out_min2;
    logic [IDX_W-1:0] out_idx;
    logic             out_sign;
    logic [IDX_W-1:0] out_deg;
    logic             deg_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int min1;
        int min2;
        int idx;
        int sgn;
        int deg;
    } exp_t;

    exp_t sb[$];

    cnu_min_accumulator #(
        .NOB(NOB), .DEG_MAX(DEG_MAX), .IDX_W(IDX_W), .OFFSET(OFFSET)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_msg(in_msg), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min1(out_min1), .out_min2(out_min2),
        .out_idx(out_idx), .out_sign(out_sign),
        .out_deg(out_deg), .deg_err(deg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int shape(input int m);
`ifdef OFFSET_MS_EN
        return (m > OFFSET) ? m - OFFSET : 0;
`else
        return m;
`endif
    endfunction

    // Reference: first occurrence of the smallest magnitude, then the
    // smallest magnitude among all other beats (15 when there are none).
    function automatic exp_t model(input int m[$]);
        exp_t e;
        int i1 = 0;
        int m2 = (1 << NOB) - 1;
        int s = 0;
        for (int i = 0; i < m.size(); i++) begin
            if ((m[i] & 15) < (m[i1] & 15)) i1 = i;
            s = s ^ ((m[i] >> NOB) & 1);
        end
        for (int i = 0; i < m.size(); i++) begin
            if (i != i1 && (m[i] & 15) < m2) m2 = m[i] & 15;
        end
        e.min1 = shape(m[i1] & 15);
        e.min2 = shape(m2);
        e.idx  = (i1 > DEG_MAX - 1) ? DEG_MAX - 1 : i1;
        e.sgn  = s;
        e.deg  = (m.size() - 1 > DEG_MAX - 1) ? DEG_MAX - 1 : m.size() - 1;
        return e;
    endfunction

    task automatic beat(input int m, input logic last);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_msg   = 5'(m);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_row(input int m[$]);
        sb.push_back(model(m));
        for (int i = 0; i < m.size(); i++) begin
            beat(m[i], (i == m.size() - 1));
        end
        // Result must be visible right after the edge that took the last beat.
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        e = sb.pop_front();
        chk({tag, ".min1"}, {28'd0, out_min1}, e.min1);
        chk({tag, ".min2"}, {28'd0, out_min2}, e.min2);
        chk({tag, ".idx"},  {27'd0, out_idx},  e.idx);
        chk({tag, ".sign"}, {31'd0, out_sign}, e.sgn);
        chk({tag, ".deg"},  {27'd0, out_deg},  e.deg);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".ready_after"}, {31'd0, in_ready},  32'd1);
        chk({tag, ".valid_drop"},  {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag, input logic [31:0] exp_err);
        chk({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".min1"},      {28'd0, out_min1},  32'd0);
        chk({tag, ".min2"},      {28'd0, out_min2},  32'd0);
        chk({tag, ".idx"},       {27'd0, out_idx},   32'd0);
        chk({tag, ".sign"},      {31'd0, out_sign},  32'd0);
        chk({tag, ".deg"},       {27'd0, out_deg},   32'd0);
        chk({tag, ".deg_err"},   {31'd0, deg_err},   exp_err);
    endtask

    initial begin
        int r[$];
        exp_t e;

        // Reset state
        #2;
        check_reset_outputs("reset", 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mixed-sign row: min1=1 at beat 4, min2=2, sign=1, deg=4
        r = '{6, 18, 25, 4, 17};
        send_row(r);
        collect("row5");

        // Backpressure, with an ignored beat offered during HOLD
        r = '{9, 3, 12, 7};
        send_row(r);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_msg   = 5'd0;
            in_last  = 1'b1;
            chk("bp.in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.min1",      {28'd0, out_min1},  e.min1);
            chk("bp.min2",      {28'd0, out_min2},  e.min2);
            chk("bp.idx",       {27'd0, out_idx},   e.idx);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        collect("bp");

        // Degree-1 row and all-equal magnitudes
        r = '{21};
        send_row(r);
        collect("deg1");
        r = '{4, 20, 4};
        send_row(r);
        collect("ties");

        // Reset in the middle of a row discards it
        beat(9, 1'b0);
        beat(24, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r = '{7, 3, 5};
        send_row(r);
        collect("after_reset");

        // Offset feature boundary (saturation at 0 when enabled)
        r = '{1, 3};
        send_row(r);
        collect("offset");

        // Over-length row: 20 beats, minimum on the final beat
        r.delete();
        for (int i = 0; i < 20; i++) r.push_back((i == 19) ? 16 : ((i % 14) + 1));
        sb.push_back(model(r));
        for (int i = 0; i < 19; i++) begin
            beat(r[i], 1'b0);
            if (i == 17) chk("deg_err_before", {31'd0, deg_err}, 32'd0);
        end
        chk("deg_err_set", {31'd0, deg_err}, 32'd1);
        beat(r[19], 1'b1);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        collect("long");

        // deg_err stays set across a normal row, clears only on reset
        r = '{2, 5};
        send_row(r);
        collect("post_long");
        chk("deg_err_sticky", {31'd0, deg_err}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("final_reset", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
